// File: rtl/verilog_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package verilog_divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  localparam int DIV_WIDTH = 32;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DIV_WIDTH);

  // Quotient reported for a zero divisor: all ones, i.e. -1.
  localparam logic signed [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/verilog_divider_sequential_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_restoring_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // One extra bit of headroom keeps the trial sign unambiguous.
  assign shifted  = {rem, dividend_msb};
  assign trial    = shifted - {2'b00, divisor_mag};
  assign q_bit    = ~trial[WIDTH+1];
  assign rem_next = trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];

endmodule

// File: rtl/verilog_divider_sequential.sv
// Iterative signed divider: one quotient bit per slow_clk, results held until the next op.
module verilog_divider_sequential
  import verilog_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             slow_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH == DIV_WIDTH) ? CNT_W : cnt_width(WIDTH);

  div_state_t       state_reg, state_next;
  logic [WIDTH-1:0] dvd_mag_reg;
  logic [WIDTH-1:0] dvs_mag_reg;
  logic [WIDTH:0]   rem_reg;
  logic [CW-1:0]    cnt_reg;
  logic             q_neg_reg;
  logic             r_neg_reg;
  logic             div0_reg;

  logic             accept;
  logic             divisor_zero;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   rem_step;
  logic             q_bit;
  logic [WIDTH-1:0] q_fix, r_mag, r_fix;

  assign busy         = (state_reg == CALC);
  assign accept       = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign divisor_zero = (divisor == '0);

  // Unsigned negation maps MIN onto 2^(WIDTH-1) without overflow.
  assign dvd_abs = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_abs = divisor[WIDTH-1]  ? -divisor  : divisor;

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem          (rem_reg),
    .dividend_msb (dvd_mag_reg[WIDTH-1]),
    .divisor_mag  (dvs_mag_reg),
    .rem_next     (rem_step),
    .q_bit        (q_bit)
  );

  // On divide-by-zero the dividend magnitude is untouched, so it doubles as the remainder.
  assign q_fix = div0_reg ? WIDTH'(DIV0_QUOTIENT)
                          : (q_neg_reg ? -dvd_mag_reg : dvd_mag_reg);
  assign r_mag = div0_reg ? dvd_mag_reg : rem_reg[WIDTH-1:0];
  assign r_fix = r_neg_reg ? -r_mag : r_mag;

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = divisor_zero ? DONE : CALC;
      CALC: if (cnt_reg == '0) state_next = DONE;
      DONE: begin
        if (start) state_next = divisor_zero ? DONE : CALC;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      dvd_mag_reg <= '0;
      dvs_mag_reg <= '0;
      rem_reg     <= '0;
      cnt_reg     <= '0;
      q_neg_reg   <= 1'b0;
      r_neg_reg   <= 1'b0;
      div0_reg    <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_reg == DONE) begin
        quotient    <= q_fix;
        remainder   <= r_fix;
        div_by_zero <= div0_reg;
        done        <= 1'b1;
      end
      if (accept) begin
        dvd_mag_reg <= dvd_abs;
        dvs_mag_reg <= dvs_abs;
        q_neg_reg   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        r_neg_reg   <= dividend[WIDTH-1];
        div0_reg    <= divisor_zero;
        rem_reg     <= '0;
        cnt_reg     <= CW'(WIDTH - 1);
      end else if (state_reg == CALC) begin
        // Quotient bits shift in behind the consumed dividend bits.
        rem_reg     <= rem_step;
        dvd_mag_reg <= {dvd_mag_reg[WIDTH-2:0], q_bit};
        cnt_reg     <= cnt_reg - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_verilog_divider_sequential.sv
// Directed, table-driven check of verilog_divider_sequential plus multi-cycle corner sequences.
module tb_verilog_divider_sequential;

  logic        slow_clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;

  verilog_divider_sequential #(.WIDTH(32)) dut (
    .slow_clk    (slow_clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 slow_clk = ~slow_clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Presents an operation for one edge; returns at the falling edge after the sampling edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge slow_clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge slow_clk);
    @(negedge slow_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int busy_cnt);
    edges = 0; busy_cnt = 0;
    while (edges < 100) begin
      if (busy) busy_cnt++;
      if (done) break;
      @(posedge slow_clk);
      edges++;
      @(negedge slow_clk);
    end
  endtask

  initial begin
    int e, bc, seen;
    vecs[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 33};
    vecs[1]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33};
    vecs[2]  = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 33};
    vecs[3]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 33};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 33};
    vecs[5]  = '{32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0, 33};
    vecs[6]  = '{32'd1234,     32'd0,        32'hFFFFFFFF, 32'd1234,     1'b1, 1};
    vecs[7]  = '{32'd9,        32'd3,        32'd3,        32'd0,        1'b0, 33};
    vecs[8]  = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0, 33};
    vecs[9]  = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0, 33};
    vecs[10] = '{32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1};
    vecs[11] = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 33};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge slow_clk);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].a, vecs[i].b);
      wait_done(e, bc);
      $display("op %0d: 0x%08h / 0x%08h -> q=0x%08h r=0x%08h dz=%0b after %0d edges",
               i, vecs[i].a, vecs[i].b, quotient, remainder, div_by_zero, e);
      check($sformatf("v%0d latency", i), e, vecs[i].lat);
      check($sformatf("v%0d quotient", i), quotient, vecs[i].q);
      check($sformatf("v%0d remainder", i), remainder, vecs[i].r);
      check($sformatf("v%0d div_by_zero", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dz});
      check($sformatf("v%0d busy cycles", i), bc, (vecs[i].lat == 33) ? 32 : 0);
      @(negedge slow_clk);
      check($sformatf("v%0d done low", i), {31'd0, done}, 32'd0);
      check($sformatf("v%0d hold quotient", i), quotient, vecs[i].q);
    end

    // start with new operands during CALC must be ignored
    launch(32'd100, 32'd7);
    repeat (5) @(negedge slow_clk);
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(negedge slow_clk);
    start = 1'b0;
    wait_done(e, bc);
    $display("ignored-start: q=0x%08h r=0x%08h after %0d edges", quotient, remainder, 6 + e);
    check("ign latency", 6 + e, 33);
    check("ign quotient", quotient, 32'd14);
    check("ign remainder", remainder, 32'd2);
    check("ign busy cycles", bc, 26);

    // start high while in DONE launches the next op back-to-back
    launch(32'd100, 32'd7);
    repeat (31) @(negedge slow_clk);
    start = 1'b1; dividend = 32'd45; divisor = 32'd5;
    wait_done(e, bc);
    start = 1'b0;
    $display("b2b first: q=0x%08h r=0x%08h after %0d edges busy=%0b", quotient, remainder, 31 + e, busy);
    check("b2b first latency", 31 + e, 33);
    check("b2b first quotient", quotient, 32'd14);
    check("b2b first remainder", remainder, 32'd2);
    check("b2b second busy", {31'd0, busy}, 32'd1);
    @(posedge slow_clk);
    @(negedge slow_clk);
    wait_done(e, bc);
    $display("b2b second: q=0x%08h r=0x%08h after %0d edges", quotient, remainder, e + 1);
    check("b2b second latency", e + 1, 33);
    check("b2b second quotient", quotient, 32'd9);
    check("b2b second remainder", remainder, 32'd0);

    // reset in cycle 10 of CALC clears everything at once, no done follows
    launch(32'd100, 32'd7);
    repeat (9) @(negedge slow_clk);
    rst = 1'b1;
    #1;
    $display("mid reset: q=0x%08h r=0x%08h busy=%0b done=%0b", quotient, remainder, busy, done);
    check("midrst quotient", quotient, 32'd0);
    check("midrst remainder", remainder, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    @(negedge slow_clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge slow_clk);
      if (done || busy) seen++;
    end
    check("midrst no activity", seen, 0);
    launch(32'd7, 32'd2);
    wait_done(e, bc);
    $display("after reset: 7 / 2 -> q=0x%08h r=0x%08h after %0d edges", quotient, remainder, e);
    check("post-rst latency", e, 33);
    check("post-rst quotient", quotient, 32'd3);
    check("post-rst remainder", remainder, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
